// File: rtl/vga_pkg.sv
// Shared scan timing defaults, scan/pixel types and the colour-bar table for the VGA path.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   typedef logic [9:0] scan_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam int BAR_WIDTH = 80;

   // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [23:0] BAR_RGB [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic rgb_t bar_colour(input scan_t x);
      logic [2:0] sel;
      sel = 3'(x / scan_t'(BAR_WIDTH));
      return rgb_t'(BAR_RGB[sel]);
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Scan-out bundle between the timing generator (master) and renderers / board pins (slave).
interface vga_timing_if;
   import vga_pkg::*;

   logic       pix_en;
   logic       test_mode;
   logic [7:0] r_in;
   logic [7:0] g_in;
   logic [7:0] b_in;

   scan_t      x_cnt;
   scan_t      y_cnt;
   logic       frame_start;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic       VGA_SYNC_N;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;

   modport master (
      input  pix_en, test_mode, r_in, g_in, b_in,
      output x_cnt, y_cnt, frame_start,
      output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
   );

   modport slave (
      output pix_en, test_mode, r_in, g_in, b_in,
      input  x_cnt, y_cnt, frame_start,
      input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping counter plus decode of active region and active-low sync.
// Latency: count is registered; wrap/active/sync_n decode the current count combinationally.
// Backpressure: none; the count holds while en is low.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   output scan_t count,
   output logic  wrap,
   output logic  active,
   output logic  sync_n
);

   localparam int    TOTAL      = ACTIVE + FP + SYNC + BP;
   localparam scan_t LAST       = scan_t'(TOTAL - 1);
   localparam scan_t ACTIVE_END = scan_t'(ACTIVE);
   localparam scan_t SYNC_FIRST = scan_t'(ACTIVE + FP);
   localparam scan_t SYNC_LAST  = scan_t'(ACTIVE + FP + SYNC - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + scan_t'(1);
      end
   end

   assign wrap   = (count == LAST);
   assign active = (count < ACTIVE_END);
   assign sync_n = !((count >= SYNC_FIRST) && (count <= SYNC_LAST));

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 scan timing with one registered stage of RGB, HS, VS and BLANK_N for the VGA DAC.
// Latency: VGA_* outputs describe the x_cnt/y_cnt of the previous pix_en cycle.
// Backpressure: none; all state holds while pix_en is low. VGA_TEST_PATTERN_EN adds colour bars.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input logic          clk,
   input logic          rst_n,
   vga_timing_if.master vga
);

   scan_t h_count;
   scan_t v_count;
   logic  h_wrap;
   logic  v_wrap;
   logic  h_active;
   logic  v_active;
   logic  h_sync_n;
   logic  v_sync_n;
   logic  video_on;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (vga.pix_en),
      .count  (h_count),
      .wrap   (h_wrap),
      .active (h_active),
      .sync_n (h_sync_n)
   );

   // The line counter advances on the same pixel that takes x back to zero.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (vga.pix_en & h_wrap),
      .count  (v_count),
      .wrap   (v_wrap),
      .active (v_active),
      .sync_n (v_sync_n)
   );

   assign video_on = h_active & v_active;

   rgb_t pix_src;

`ifdef VGA_TEST_PATTERN_EN
   always_comb begin
      pix_src = '{r: vga.r_in, g: vga.g_in, b: vga.b_in};
      if (vga.test_mode) begin
         pix_src = bar_colour(h_count);
      end
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = vga.test_mode;
   assign pix_src          = '{r: vga.r_in, g: vga.g_in, b: vga.b_in};
`endif

   rgb_t pix_q;
   logic hs_q;
   logic vs_q;
   logic blank_n_q;
   logic frame_start_q;

   // frame_start marks the pixel whose successor counts are (0,0), so it is never set out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q         <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (vga.pix_en) begin
         pix_q         <= video_on ? pix_src : '0;
         hs_q          <= h_sync_n;
         vs_q          <= v_sync_n;
         blank_n_q     <= video_on;
         frame_start_q <= h_wrap & v_wrap;
      end
   end

   assign vga.x_cnt       = h_count;
   assign vga.y_cnt       = v_count;
   assign vga.frame_start = frame_start_q;
   assign vga.VGA_HS      = hs_q;
   assign vga.VGA_VS      = vs_q;
   assign vga.VGA_BLANK_N = blank_n_q;
   assign vga.VGA_SYNC_N  = 1'b0;
   assign vga.VGA_R       = pix_q.r;
   assign vga.VGA_G       = pix_q.g;
   assign vga.VGA_B       = pix_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-timing instance plus a shrunken-timing instance for frame checks.
module tb_vga_timing;
   import vga_pkg::*;

   localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 3;
   localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 3;
   localparam int HT_S = SHA + SHF + SHS + SHB;
   localparam int FR_S = HT_S * (SVA + SVF + SVS + SVB);
`ifdef VGA_TEST_PATTERN_EN
   localparam bit PAT_BUILD = 1'b1;
`else
   localparam bit PAT_BUILD = 1'b0;
`endif

   typedef struct packed {
      scan_t      x;
      scan_t      y;
      logic       fs;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       sync_n;
      logic [23:0] rgb;
   } out_t;

   logic        clk;
   logic        rst_n;
   bit          cur_pe;
   logic        rmode;
   logic [23:0] seed;
   int          n;
   int          tests;
   int          fails;

   vga_timing_if vif ();
   vga_timing_if sif ();

   vga_timing dut (.clk(clk), .rst_n(rst_n), .vga(vif));

   vga_timing #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) dut_s (.clk(clk), .rst_n(rst_n), .vga(sif));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] render(input scan_t x, input scan_t y, input logic m,
                                          input logic [23:0] s);
      if (!m) return {x[7:0], y[7:0], 8'h5A};
      return {x[7:0] ^ s[23:16], y[7:0] + s[15:8], x[9:2] ^ y[7:0] ^ s[7:0]};
   endfunction

   always_comb {vif.r_in, vif.g_in, vif.b_in} = render(vif.x_cnt, vif.y_cnt, rmode, seed);
   always_comb {sif.r_in, sif.g_in, sif.b_in} = render(sif.x_cnt, sif.y_cnt, rmode, seed);

   function automatic logic [23:0] bar_ref(input int px);
      case (px / 80)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Expected outputs after n pixel steps since release, from the global pixel index alone.
   function automatic out_t model(input bit sml, input int steps, input bit pat);
      int ha, hf, hw, hb, va, vf, vw, vb, ht, vt, fr, cur, p, px, py;
      out_t o;
      if (sml) begin
         ha = SHA; hf = SHF; hw = SHS; hb = SHB; va = SVA; vf = SVF; vw = SVS; vb = SVB;
      end else begin
         ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33;
      end
      ht  = ha + hf + hw + hb;
      vt  = va + vf + vw + vb;
      fr  = ht * vt;
      cur = steps % fr;
      o   = '0;
      o.x = scan_t'(cur % ht);
      o.y = scan_t'(cur / ht);
      if (steps == 0) begin
         o.hs = 1'b1;
         o.vs = 1'b1;
      end else begin
         p       = (steps - 1) % fr;
         px      = p % ht;
         py      = p / ht;
         o.fs    = (cur == 0);
         o.hs    = !(px >= ha + hf && px < ha + hf + hw);
         o.vs    = !(py >= va + vf && py < va + vf + vw);
         o.blank = (px < ha) && (py < va);
         if (o.blank) o.rgb = pat ? bar_ref(px) : render(scan_t'(px), scan_t'(py), rmode, seed);
      end
      return o;
   endfunction

   function automatic out_t obs(input bit sml);
      if (sml)
         return {sif.x_cnt, sif.y_cnt, sif.frame_start, sif.VGA_HS, sif.VGA_VS,
                 sif.VGA_BLANK_N, sif.VGA_SYNC_N, sif.VGA_R, sif.VGA_G, sif.VGA_B};
      return {vif.x_cnt, vif.y_cnt, vif.frame_start, vif.VGA_HS, vif.VGA_VS,
              vif.VGA_BLANK_N, vif.VGA_SYNC_N, vif.VGA_R, vif.VGA_G, vif.VGA_B};
   endfunction

   task automatic set_pe(input bit v);
      cur_pe     = v;
      vif.pix_en = v;
      sif.pix_en = v;
   endtask

   task automatic set_tm(input bit v);
      vif.test_mode = v;
      sif.test_mode = v;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n && cur_pe) n++;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_pe(1'b1);
      repeat (3) tick();
      rst_n = 1'b1;
      n     = 0;
   endtask

   task automatic test_reset();
      out_t e, o;
      e    = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      rst_n = 1'b0;
      set_pe(1'b1);
      repeat (4) tick();
      for (int s = 0; s < 2; s++) begin
         o = obs(s[0]);
         tests++;
         if (o !== e) begin
            fails++;
            $display("FAIL reset_hold dut%0d: got %h want %h", s, o, e);
         end
      end
      rst_n = 1'b1;
      n     = 0;
      repeat (300) tick();
      o = obs(1'b0);
      tests++;
      if (o.x !== scan_t'(300)) begin
         fails++;
         $display("FAIL reset_mid_pre: x_cnt %0d want 300", o.x);
      end
      rst_n = 1'b0;
      n     = 0;
      #1;
      for (int s = 0; s < 2; s++) begin
         o = obs(s[0]);
         tests++;
         if (o !== e) begin
            fails++;
            $display("FAIL reset_mid_async dut%0d: got %h want %h", s, o, e);
         end
      end
      tick();
      rst_n = 1'b1;
      tick();
      o = obs(1'b0);
      e = model(1'b0, n, 1'b0);
      tests++;
      if (o !== e) begin
         fails++;
         $display("FAIL reset_restart: got %h want %h", o, e);
      end
   endtask

   task automatic test_horizontal();
      out_t o, e, fo, fe;
      int bad, hs_lo;
      scan_t first_x;
      bad = 0; hs_lo = 0; first_x = '0; fo = '0; fe = '0;
      rmode = 1'b0; set_tm(1'b0);
      do_reset();
      for (int i = 0; i < 1600; i++) begin
         tick();
         o = obs(1'b0);
         e = model(1'b0, n, 1'b0);
         if (o !== e) begin
            bad++;
            if (bad == 1) begin fo = o; fe = e; end
         end
         if (n <= 800 && !o.hs) begin
            hs_lo++;
            if (hs_lo == 1) first_x = o.x;
         end
         if (n == 800) begin
            tests++;
            if (o.x !== scan_t'(0) || o.y !== scan_t'(1)) begin
               fails++;
               $display("FAIL h_wrap: x=%0d y=%0d want x=0 y=1", o.x, o.y);
            end
         end
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL h_scan: %0d bad cycles, first got %h want %h", bad, fo, fe);
      end
      tests++;
      if (hs_lo !== 96) begin
         fails++;
         $display("FAIL hs_width: %0d cycles want 96", hs_lo);
      end
      tests++;
      if (first_x !== scan_t'(657)) begin
         fails++;
         $display("FAIL hs_start: first low at x_cnt %0d want 657", first_x);
      end
   endtask

   task automatic test_pipeline();
      out_t o;
      rmode = 1'b0; set_tm(1'b0);
      do_reset();
      repeat (20 * 800 + 10) tick();
      tick();
      o = obs(1'b0);
      tests++;
      if (o.rgb !== 24'h0A145A || o.blank !== 1'b1) begin
         fails++;
         $display("FAIL pipe_10_20: rgb %h blank %b want 0a145a blank 1", o.rgb, o.blank);
      end
      repeat (629) tick();
      tests++;
      if (vif.x_cnt !== scan_t'(640)) begin
         fails++;
         $display("FAIL pipe_at_640: x_cnt %0d want 640", vif.x_cnt);
      end
      tick();
      o = obs(1'b0);
      tests++;
      if (o.rgb !== 24'h000000 || o.blank !== 1'b0) begin
         fails++;
         $display("FAIL pipe_blank: rgb %h blank %b want 000000 blank 0", o.rgb, o.blank);
      end
   endtask

   task automatic test_enable();
      out_t o, e, fo, fe;
      int bad, hs_clk;
      bad = 0; hs_clk = 0; fo = '0; fe = '0;
      rmode = 1'b0; set_tm(1'b0);
      do_reset();
      for (int i = 0; i < 1700; i++) begin
         set_pe(i % 2 == 0);
         tick();
         o = obs(1'b0);
         e = model(1'b0, n, 1'b0);
         if (o !== e) begin
            bad++;
            if (bad == 1) begin fo = o; fe = e; end
         end
         if (!o.hs) hs_clk++;
      end
      set_pe(1'b1);
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL enable_scan: %0d bad cycles, first got %h want %h", bad, fo, fe);
      end
      tests++;
      if (hs_clk !== 192) begin
         fails++;
         $display("FAIL enable_hs_width: %0d clk cycles want 192", hs_clk);
      end
   endtask

   task automatic test_frame();
      out_t o, e, fo, fe;
      int bad, vs_lo;
      int rises[$];
      bit prev_fs;
      scan_t vs_x, vs_y;
      bad = 0; vs_lo = 0; prev_fs = 1'b0; vs_x = '0; vs_y = '0; fo = '0; fe = '0;
      rmode = 1'b0; set_tm(1'b0);
      do_reset();
      for (int i = 0; i < 3 * FR_S + 4; i++) begin
         tick();
         o = obs(1'b1);
         e = model(1'b1, n, 1'b0);
         if (o !== e) begin
            bad++;
            if (bad == 1) begin fo = o; fe = e; end
         end
         if (o.fs && !prev_fs) rises.push_back(n);
         prev_fs = o.fs;
         if (n <= FR_S && !o.vs) begin
            vs_lo++;
            if (vs_lo == 1) begin vs_x = o.x; vs_y = o.y; end
         end
         if (n == FR_S) begin
            set_pe(1'b0);
            for (int k = 0; k < 4; k++) begin
               tick();
               tests++;
               if (sif.frame_start !== 1'b1) begin
                  fails++;
                  $display("FAIL fs_hold stall %0d: frame_start %b want 1", k, sif.frame_start);
               end
            end
            set_pe(1'b1);
         end
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL frame_scan: %0d bad cycles, first got %h want %h", bad, fo, fe);
      end
      tests++;
      if (rises.size() !== 3 || rises[0] !== FR_S || rises[1] !== 2 * FR_S || rises[2] !== 3 * FR_S) begin
         fails++;
         $display("FAIL fs_period: %0d pulses, first at %0d want 3 pulses every %0d",
                  rises.size(), (rises.size() > 0) ? rises[0] : -1, FR_S);
      end
      tests++;
      if (vs_lo !== SVS * HT_S) begin
         fails++;
         $display("FAIL vs_width: %0d cycles want %0d", vs_lo, SVS * HT_S);
      end
      tests++;
      if (vs_x !== scan_t'(1) || vs_y !== scan_t'(SVA + SVF)) begin
         fails++;
         $display("FAIL vs_start: first low at (%0d,%0d) want (1,%0d)", vs_x, vs_y, SVA + SVF);
      end
   endtask

   task automatic test_pattern();
      logic [23:0] want [3];
      int          xs   [3];
      out_t o;
`ifdef VGA_TEST_PATTERN_EN
      want[0] = 24'hFFFF00; want[1] = 24'h0000FF; want[2] = 24'h000000;
`else
      want[0] = 24'h55005A; want[1] = 24'hF4005A; want[2] = 24'h7F005A;
`endif
      xs[0] = 85; xs[1] = 500; xs[2] = 639;
      rmode = 1'b0; set_tm(1'b1);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         while (n < xs[k]) tick();
         tick();
         o = obs(1'b0);
         tests++;
         if (o.rgb !== want[k] || o.blank !== 1'b1) begin
            fails++;
            $display("FAIL pattern_x%0d: rgb %h blank %b want %h blank 1", xs[k], o.rgb, o.blank, want[k]);
         end
      end
      set_tm(1'b0);
   endtask

   task automatic test_random();
      out_t o, e, fo, fe;
      int bad, dens, rst_at;
      bit tm;
      for (int r = 0; r < 20; r++) begin
         bad = 0; fo = '0; fe = '0;
         seed   = 24'($urandom);
         rmode  = 1'b1;
         tm     = 1'($urandom_range(0, 1));
         dens   = $urandom_range(1, 4);
         rst_at = $urandom_range(200, 900);
         set_tm(tm);
         do_reset();
         for (int k = 0; k < 1000; k++) begin
            set_pe($urandom_range(0, 3) < dens);
            tick();
            if (k == rst_at) begin
               rst_n = 1'b0;
               n     = 0;
               #1;
            end
            if (k == rst_at + 3) rst_n = 1'b1;
            for (int s = 0; s < 2; s++) begin
               o = obs(s[0]);
               e = model(s[0], n, PAT_BUILD && tm);
               if (o !== e) begin
                  bad++;
                  if (bad == 1) begin fo = o; fe = e; end
               end
            end
         end
         tests++;
         if (bad !== 0) begin
            fails++;
            $display("FAIL random_round%0d: %0d bad samples, first got %h want %h", r, bad, fo, fe);
         end
      end
      set_pe(1'b1);
      set_tm(1'b0);
      rmode = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      n     = 0;
      rmode = 1'b0;
      seed  = '0;
      rst_n = 1'b0;
      set_pe(1'b1);
      set_tm(1'b0);
      test_reset();
      test_horizontal();
      test_pipeline();
      test_enable();
      test_frame();
      test_pattern();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
